// File: rtl/cmp_arbiter.sv
// -----------------------------------------------------------------------------
// cmp_arbiter
//
// Lets NUM_REQ requesters share one combinational branch comparator.
// A round-robin arbiter picks one request per cycle and steers its op and
// operands onto the comparator. The comparator's br_en is captured into a
// one-entry result register with a valid/ready handshake.
//
// Ports
//   clk          clock; all state changes on the rising edge
//   rst_n        synchronous active-low reset
//   flush        drops the held result and blocks any grant this cycle
//   req_valid    per-requester request valid
//   req_ready    one-hot grant; combinational from req_valid and state
//   req_op       3-bit branch funct3 per requester, slice [3i+2:3i]
//   req_a/req_b  32-bit operands per requester
//   req_tag      TAG_W-bit tag per requester, returned with the result
//   cmp_op/a/b   drive to the shared comparator
//   cmp_br_en    branch decision from the shared comparator
//   res_valid    result register holds a result
//   res_ready    consumer takes the result this cycle
//   res_br_en    captured branch decision (0 for illegal ops)
//   res_illegal  captured op was funct3 010 or 011
//   res_src      index of the requester that produced the result
//   res_tag      tag of that request
// -----------------------------------------------------------------------------
module cmp_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int TAG_W   = 4,
  localparam int SRC_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [3*NUM_REQ-1:0]     req_op,
  input  logic [32*NUM_REQ-1:0]    req_a,
  input  logic [32*NUM_REQ-1:0]    req_b,
  input  logic [TAG_W*NUM_REQ-1:0] req_tag,
  output logic [2:0]               cmp_op,
  output logic [31:0]              cmp_a,
  output logic [31:0]              cmp_b,
  input  logic                     cmp_br_en,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic                     res_br_en,
  output logic                     res_illegal,
  output logic [SRC_W-1:0]         res_src,
  output logic [TAG_W-1:0]         res_tag
);

  // Per-requester views of the flattened request buses.
  logic [2:0]       op_arr  [NUM_REQ];
  logic [31:0]      a_arr   [NUM_REQ];
  logic [31:0]      b_arr   [NUM_REQ];
  logic [TAG_W-1:0] tag_arr [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
    assign op_arr[gi]  = req_op[3*gi +: 3];
    assign a_arr[gi]   = req_a[32*gi +: 32];
    assign b_arr[gi]   = req_b[32*gi +: 32];
    assign tag_arr[gi] = req_tag[TAG_W*gi +: TAG_W];
  end

  // State
  logic [SRC_W-1:0] ptr_q, ptr_d;
  logic             res_valid_q, res_valid_d;
  logic             res_br_en_q, res_br_en_d;
  logic             res_illegal_q, res_illegal_d;
  logic [SRC_W-1:0] res_src_q, res_src_d;
  logic [TAG_W-1:0] res_tag_q, res_tag_d;

  // Round-robin search starting at ptr_q. idx_w is one bit wider than an
  // index so ptr + offset can be wrapped with a single subtraction.
  logic             found;
  logic [SRC_W-1:0] found_idx;
  logic [SRC_W:0]   idx_w;

  always_comb begin
    found     = 1'b0;
    found_idx = '0;
    idx_w     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx_w = {1'b0, ptr_q} + (SRC_W+1)'(k);
      if (idx_w >= (SRC_W+1)'(NUM_REQ)) begin
        idx_w = idx_w - (SRC_W+1)'(NUM_REQ);
      end
      if (!found && req_valid[idx_w[SRC_W-1:0]]) begin
        found     = 1'b1;
        found_idx = idx_w[SRC_W-1:0];
      end
    end
  end

  // A grant needs a free result slot: empty, or being popped this cycle.
  logic             slot_free;
  logic             grant;
  logic [SRC_W-1:0] sel_idx;
  logic [2:0]       sel_op;
  logic             op_illegal;

  assign slot_free  = !res_valid_q || res_ready;
  assign grant      = found && slot_free && !flush && rst_n;
  // Requester 0 drives the comparator when nobody is granted.
  assign sel_idx    = grant ? found_idx : '0;
  assign sel_op     = op_arr[sel_idx];
  // funct3 010 and 011 have no branch meaning.
  assign op_illegal = (sel_op[2:1] == 2'b01);

  always_comb begin
    req_ready = '0;
    if (grant) begin
      req_ready[sel_idx] = 1'b1;
    end
  end

  // The comparator decodes op with a unique case, so only legal values
  // are ever presented to it.
  assign cmp_op = (grant && !op_illegal) ? sel_op : 3'b000;
  assign cmp_a  = a_arr[sel_idx];
  assign cmp_b  = b_arr[sel_idx];

  // Next-state for result register and pointer.
  always_comb begin
    ptr_d         = ptr_q;
    res_valid_d   = res_valid_q;
    res_br_en_d   = res_br_en_q;
    res_illegal_d = res_illegal_q;
    res_src_d     = res_src_q;
    res_tag_d     = res_tag_q;
    if (grant) begin
      // A grant also covers the pop-and-refill case with no bubble.
      res_valid_d   = 1'b1;
      res_br_en_d   = cmp_br_en && !op_illegal;
      res_illegal_d = op_illegal;
      res_src_d     = sel_idx;
      res_tag_d     = tag_arr[sel_idx];
      ptr_d         = (sel_idx == SRC_W'(NUM_REQ-1)) ? '0 : sel_idx + 1'b1;
    end else if (flush || res_ready) begin
      res_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q         <= '0;
      res_valid_q   <= 1'b0;
      res_br_en_q   <= 1'b0;
      res_illegal_q <= 1'b0;
      res_src_q     <= '0;
      res_tag_q     <= '0;
    end else begin
      ptr_q         <= ptr_d;
      res_valid_q   <= res_valid_d;
      res_br_en_q   <= res_br_en_d;
      res_illegal_q <= res_illegal_d;
      res_src_q     <= res_src_d;
      res_tag_q     <= res_tag_d;
    end
  end

  assign res_valid   = res_valid_q;
  assign res_br_en   = res_br_en_q;
  assign res_illegal = res_illegal_q;
  assign res_src     = res_src_q;
  assign res_tag     = res_tag_q;

endmodule

// File: tb/tb_cmp_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cmp_arbiter
//
// Directed bench for cmp_arbiter with NUM_REQ=2, TAG_W=4. A behavioural
// branch comparator closes the cmp_* loop. Inputs change 1 time unit after
// the rising edge; combinational outputs are checked 1 unit later and
// registered outputs 1 unit after the edge.
// -----------------------------------------------------------------------------
module tb_cmp_arbiter;
  localparam int NUM_REQ = 2;
  localparam int TAG_W   = 4;

  logic                     clk;
  logic                     rst_n;
  logic                     flush;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [3*NUM_REQ-1:0]     req_op;
  logic [32*NUM_REQ-1:0]    req_a;
  logic [32*NUM_REQ-1:0]    req_b;
  logic [TAG_W*NUM_REQ-1:0] req_tag;
  logic [2:0]               cmp_op;
  logic [31:0]              cmp_a;
  logic [31:0]              cmp_b;
  logic                     cmp_br_en;
  logic                     res_valid;
  logic                     res_ready;
  logic                     res_br_en;
  logic                     res_illegal;
  logic [0:0]               res_src;
  logic [TAG_W-1:0]         res_tag;

  int err_cnt = 0;
  int chk_cnt = 0;

  cmp_arbiter #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .cmp_op(cmp_op), .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_br_en(cmp_br_en),
    .res_valid(res_valid), .res_ready(res_ready), .res_br_en(res_br_en),
    .res_illegal(res_illegal), .res_src(res_src), .res_tag(res_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared branch comparator model.
  always_comb begin
    cmp_br_en = 1'b0;
    case (cmp_op)
      3'b000: cmp_br_en = (cmp_a == cmp_b);
      3'b001: cmp_br_en = (cmp_a != cmp_b);
      3'b100: cmp_br_en = ($signed(cmp_a) <  $signed(cmp_b));
      3'b101: cmp_br_en = ($signed(cmp_a) >= $signed(cmp_b));
      3'b110: cmp_br_en = (cmp_a <  cmp_b);
      3'b111: cmp_br_en = (cmp_a >= cmp_b);
      default: cmp_br_en = 1'b0;
    endcase
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] tag);
    req_valid[i]       = v;
    req_op[3*i +: 3]   = op;
    req_a[32*i +: 32]  = a;
    req_b[32*i +: 32]  = b;
    req_tag[4*i +: 4]  = tag;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [2:0] sw_op  [4];
  logic       sw_exp [4];

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    sw_op[0] = 3'b101; sw_exp[0] = 1'b0;  // bge:  signed  min >= max -> 0
    sw_op[1] = 3'b111; sw_exp[1] = 1'b1;  // bgeu: 0x8000_0000 >= 0x7FFF_FFFF
    sw_op[2] = 3'b000; sw_exp[2] = 1'b0;  // beq
    sw_op[3] = 3'b001; sw_exp[3] = 1'b1;  // bne

    // Reset with requests pending: no grant, outputs cleared.
    rst_n = 1'b0; flush = 1'b0; res_ready = 1'b0;
    req_valid = '0; req_op = '0; req_a = '0; req_b = '0; req_tag = '0;
    set_req(0, 1'b1, 3'b000, 32'd0, 32'd0, 4'd1);
    set_req(1, 1'b1, 3'b000, 32'd0, 32'd0, 4'd2);
    step(); step();
    #1;
    check_eq("rst_req_ready", 32'(req_ready), 32'h0);
    check_eq("rst_res_valid", 32'(res_valid), 32'h0);
    check_eq("rst_res_br_en", 32'(res_br_en), 32'h0);
    check_eq("rst_res_illegal", 32'(res_illegal), 32'h0);
    check_eq("rst_res_src", 32'(res_src), 32'h0);
    check_eq("rst_res_tag", 32'(res_tag), 32'h0);

    // Single request, blt signed: -1 < 1.
    rst_n = 1'b1;
    set_req(1, 1'b0, 3'b000, 32'd0, 32'd0, 4'd0);
    set_req(0, 1'b1, 3'b100, 32'hFFFF_FFFF, 32'd1, 4'd3);
    res_ready = 1'b1;
    #1;
    check_eq("blt_req_ready", 32'(req_ready), 32'h1);
    check_eq("blt_cmp_op", 32'(cmp_op), 32'h4);
    step();
    check_eq("blt_res_valid", 32'(res_valid), 32'h1);
    check_eq("blt_res_br_en", 32'(res_br_en), 32'h1);
    check_eq("blt_res_src", 32'(res_src), 32'h0);
    check_eq("blt_res_tag", 32'(res_tag), 32'h3);

    // Same operands, bltu: 0xFFFFFFFF < 1 is false. Pointer is 1 but req1
    // is idle, so the search wraps to req0.
    set_req(0, 1'b1, 3'b110, 32'hFFFF_FFFF, 32'd1, 4'd4);
    #1;
    check_eq("bltu_req_ready", 32'(req_ready), 32'h1);
    step();
    check_eq("bltu_res_valid", 32'(res_valid), 32'h1);
    check_eq("bltu_res_br_en", 32'(res_br_en), 32'h0);
    check_eq("bltu_res_tag", 32'(res_tag), 32'h4);

    // Pop with no new request empties the slot.
    set_req(0, 1'b0, 3'b000, 32'd0, 32'd0, 4'd0);
    #1;
    check_eq("pop_req_ready", 32'(req_ready), 32'h0);
    step();
    check_eq("pop_res_valid", 32'(res_valid), 32'h0);

    // req1 alone: bne 1,2 -> 1. Leaves pointer at 0.
    set_req(1, 1'b1, 3'b001, 32'd1, 32'd2, 4'd7);
    #1;
    check_eq("r1_req_ready", 32'(req_ready), 32'h2);
    step();
    check_eq("r1_res_valid", 32'(res_valid), 32'h1);
    check_eq("r1_res_br_en", 32'(res_br_en), 32'h1);
    check_eq("r1_res_src", 32'(res_src), 32'h1);
    check_eq("r1_res_tag", 32'(res_tag), 32'h7);

    // Contention: grants alternate 0,1,0,1 with results one cycle behind.
    set_req(0, 1'b1, 3'b000, 32'd0, 32'd0, 4'hA);  // beq 0,0 -> 1
    set_req(1, 1'b1, 3'b001, 32'd0, 32'd0, 4'hB);  // bne 0,0 -> 0
    for (int c = 0; c < 4; c++) begin
      #1;
      check_eq($sformatf("cont%0d_req_ready", c), 32'(req_ready), (c % 2 == 0) ? 32'h1 : 32'h2);
      step();
      check_eq($sformatf("cont%0d_res_valid", c), 32'(res_valid), 32'h1);
      check_eq($sformatf("cont%0d_res_src", c), 32'(res_src), 32'(c % 2));
      check_eq($sformatf("cont%0d_res_tag", c), 32'(res_tag), (c % 2 == 0) ? 32'hA : 32'hB);
      check_eq($sformatf("cont%0d_res_br_en", c), 32'(res_br_en), (c % 2 == 0) ? 32'h1 : 32'h0);
    end

    // Backpressure: result from req1 (tag B, br_en 0) must hold.
    set_req(0, 1'b0, 3'b000, 32'd0, 32'd0, 4'd0);
    set_req(1, 1'b1, 3'b110, 32'd1, 32'd2, 4'hC);  // bltu 1<2 -> 1
    res_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      check_eq($sformatf("bp%0d_req_ready", c), 32'(req_ready), 32'h0);
      check_eq($sformatf("bp%0d_res_valid", c), 32'(res_valid), 32'h1);
      check_eq($sformatf("bp%0d_res_src", c), 32'(res_src), 32'h1);
      check_eq($sformatf("bp%0d_res_tag", c), 32'(res_tag), 32'hB);
      check_eq($sformatf("bp%0d_res_br_en", c), 32'(res_br_en), 32'h0);
      step();
    end
    res_ready = 1'b1;
    #1;
    check_eq("bp_release_req_ready", 32'(req_ready), 32'h2);
    step();
    check_eq("bp_release_res_valid", 32'(res_valid), 32'h1);
    check_eq("bp_release_res_tag", 32'(res_tag), 32'hC);
    check_eq("bp_release_res_br_en", 32'(res_br_en), 32'h1);

    // Illegal op 010 with a==b: comparator sees beq, result still forced 0.
    set_req(1, 1'b0, 3'b000, 32'd0, 32'd0, 4'd0);
    set_req(0, 1'b1, 3'b010, 32'd5, 32'd5, 4'd5);
    #1;
    check_eq("ill_req_ready", 32'(req_ready), 32'h1);
    check_eq("ill_cmp_op", 32'(cmp_op), 32'h0);
    step();
    check_eq("ill_res_valid", 32'(res_valid), 32'h1);
    check_eq("ill_res_illegal", 32'(res_illegal), 32'h1);
    check_eq("ill_res_br_en", 32'(res_br_en), 32'h0);
    check_eq("ill_res_tag", 32'(res_tag), 32'h5);

    // Signed/unsigned sweep through req1, back to back.
    set_req(0, 1'b0, 3'b000, 32'd0, 32'd0, 4'd0);
    for (int i = 0; i < 4; i++) begin
      set_req(1, 1'b1, sw_op[i], 32'h8000_0000, 32'h7FFF_FFFF, 4'(8 + i));
      #1;
      check_eq($sformatf("sw%0d_req_ready", i), 32'(req_ready), 32'h2);
      check_eq($sformatf("sw%0d_cmp_op", i), 32'(cmp_op), 32'(sw_op[i]));
      step();
      check_eq($sformatf("sw%0d_res_br_en", i), 32'(res_br_en), 32'(sw_exp[i]));
      check_eq($sformatf("sw%0d_res_illegal", i), 32'(res_illegal), 32'h0);
      check_eq($sformatf("sw%0d_res_src", i), 32'(res_src), 32'h1);
      check_eq($sformatf("sw%0d_res_tag", i), 32'(res_tag), 32'(8 + i));
    end

    // Flush while stalled with both requesting; pointer (0) must not move.
    set_req(0, 1'b1, 3'b000, 32'd1, 32'd1, 4'd6);
    set_req(1, 1'b1, 3'b000, 32'd0, 32'd0, 4'hD);
    res_ready = 1'b0;
    flush = 1'b1;
    #1;
    check_eq("fl_req_ready", 32'(req_ready), 32'h0);
    step();
    check_eq("fl_res_valid", 32'(res_valid), 32'h0);
    flush = 1'b0;
    res_ready = 1'b1;
    #1;
    check_eq("fl_after_req_ready", 32'(req_ready), 32'h1);
    step();
    check_eq("fl_after_res_valid", 32'(res_valid), 32'h1);
    check_eq("fl_after_res_src", 32'(res_src), 32'h0);
    check_eq("fl_after_res_tag", 32'(res_tag), 32'h6);
    check_eq("fl_after_res_br_en", 32'(res_br_en), 32'h1);

    // Mid-operation reset: result discarded, pointer (1) back to 0.
    rst_n = 1'b0;
    #1;
    check_eq("mrst_req_ready", 32'(req_ready), 32'h0);
    step();
    check_eq("mrst_res_valid", 32'(res_valid), 32'h0);
    check_eq("mrst_res_br_en", 32'(res_br_en), 32'h0);
    check_eq("mrst_res_src", 32'(res_src), 32'h0);
    check_eq("mrst_res_tag", 32'(res_tag), 32'h0);
    rst_n = 1'b1;
    #1;
    check_eq("mrst_ptr_req_ready", 32'(req_ready), 32'h1);
    step();
    check_eq("mrst_after_res_tag", 32'(res_tag), 32'h6);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/cmp_arbiter.md
Name: cmp_arbiter

Overview:
- Shares the single combinational branch comparator among NUM_REQ requesters, such as multiple issue slots or reservation stations.
- Arbitrates round-robin, drives the comparator's op/operand inputs, and captures its br_en into a registered result stage with a valid/ready handshake.
- Sits between the branch-issue logic and the fetch/redirect logic.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
TAG_W, 4, width of the per-request tag carried through to the result

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  synchronous active-low reset
flush  in  1  kill the registered result and refuse grants this cycle
req_valid  in  NUM_REQ  requester i holds a compare request
req_ready  out  NUM_REQ  one-hot grant; request i accepted when req_valid[i] && req_ready[i]
req_op  in  3*NUM_REQ  branch_funct3_t per requester, slice [3i+2:3i]
req_a  in  32*NUM_REQ  rv32i_word operand a per requester
req_b  in  32*NUM_REQ  rv32i_word operand b per requester
req_tag  in  TAG_W*NUM_REQ  tag per requester
cmp_op  out  3  to shared comparator cmpop
cmp_a  out  32  to shared comparator a
cmp_b  out  32  to shared comparator b
cmp_br_en  in  1  from shared comparator br_en
res_valid  out  1  result register holds a valid result
res_ready  in  1  consumer accepts the result this cycle
res_br_en  out  1  captured branch decision
res_illegal  out  1  request carried funct3 010 or 011
res_src  out  $clog2(NUM_REQ)  index of the requester that produced the result
res_tag  out  TAG_W  tag of that request

Behaviour:
- Reset (rst_n=0 at a clock edge): res_valid=0, res_br_en=0, res_illegal=0, res_src=0, res_tag=0, round-robin pointer=0. req_ready is combinationally 0 while rst_n=0.
- Slot free when `!res_valid || res_ready`. Grant only if slot free && !flush && rst_n.
- Arbitration, combinational in the same cycle: search req_valid starting at the pointer, wrapping at NUM_REQ. The first valid index g gets req_ready[g]=1; all other req_ready bits are 0. No grant means req_ready is all zero.
- req_ready may depend on req_valid; requesters must not depend on req_ready to raise valid.
- Pointer update: on a grant, the pointer becomes (g+1) mod NUM_REQ. It is unchanged otherwise, so the same requester is not favoured twice in a row under contention.
- Comparator drive:
  - cmp_a/cmp_b come from the granted slice, or from requester 0 when there is no grant.
  - cmp_op is the granted op. If that op is 010 or 011 (illegal), or there is no grant, cmp_op=beq (000), so the comparator's unique case never sees an illegal value.
- Capture on grant, at the next edge:
  - res_valid=1.
  - res_br_en = cmp_br_en, forced to 0 if the op was illegal.
  - res_illegal = 1 if the op was 010/011.
  - res_src=g, res_tag = granted tag.
- Latency: 1 cycle from accept to res_valid. Throughput is 1 result/cycle when res_ready is held high.
- Result held stable while `res_valid && !res_ready` (backpressure). req_ready is all zero during that time.
- Simultaneous pop and grant (res_valid && res_ready && grant): the new result replaces the old with no bubble.
- Pop without grant: res_valid goes to 0 next cycle.
- flush=1: res_valid goes to 0 next cycle regardless of res_ready. No grant that cycle and the pointer is unchanged. The other res_* outputs may hold stale values.
- rst_n=0 mid-operation overrides flush and any grant. The in-flight result is discarded.
- Requests must hold valid and payload stable until accepted. The block does not buffer requests.
- Compare semantics come entirely from the shared comparator: signed for blt/bge, unsigned for bltu/bgeu.

Test Plan:
- Single request: req0 valid, op=blt, a=0xFFFFFFFF, b=1, tag=3, res_ready=1. Required: req_ready=01 same cycle; next cycle res_valid=1, res_br_en=1, res_src=0, res_tag=3. Repeat with op=bltu: res_br_en=0.
- Contention: both requesters valid for 4 cycles, res_ready=1. Required: grants alternate 0,1,0,1; res_src sequence 0,1,0,1 with 1-cycle lag and no bubbles.
- Backpressure: result valid, res_ready=0 for 3 cycles while req1 valid. Required: req_ready=00 and res_* stable throughout. Raising res_ready grants req1 in that same cycle, and its result appears the next cycle.
- Illegal op: req0 op=3'b010, a=b=5. Required: cmp_op=000 that cycle; next cycle res_illegal=1, res_br_en=0.
- Flush: res_valid=1, res_ready=0, req0 valid, flush=1. Required: req_ready=00, res_valid=0 next cycle, pointer unchanged so req0 is granted the following cycle. Reset: rst_n=0 with res_valid=1. Required: all outputs 0 next cycle.
- bge/bgeu/beq/bne sweep through requester 1 with a=0x80000000, b=0x7FFFFFFF. Required br_en: bge=0, bgeu=1, beq=0, bne=1.
